// File: rtl/avalon_bram_burst_if.sv
// Avalon-MM burst bus bundle for avalon_bram_burst; ADDR_W is derived from
// the data width and the RAM depth.
interface avalon_bram_burst_if #(
    parameter int DATA_W       = 32,
    parameter int RAM_ADD_W    = 8,
    parameter int BURSTCOUNT_W = 4
);
    localparam int BYTES  = DATA_W / 8;
    localparam int ADDR_W = RAM_ADD_W + $clog2(BYTES);

    logic [ADDR_W-1:0]       address;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic                    read;
    logic                    write;
    logic [DATA_W-1:0]       writedata;
    logic [BYTES-1:0]        byteenable;
    logic                    waitrequest;
    logic [DATA_W-1:0]       readdata;
    logic                    readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_bram_burst.sv
// Avalon-MM burst agent over byte-lane block RAM with wrapping linear bursts.
// Define AVALON_BRAM_OUT_REG_EN to add an output register (read latency 2 instead of 1).
//
// state    | meaning
// IDLE     | accepting commands; single-beat writes complete here
// RD_BURST | issuing one read beat per cycle, then draining until the last beat is valid
// WR_BURST | accepting write beats 1..N-1; write=0 stalls
module avalon_bram_burst #(
    parameter int DATA_W       = 32,
    parameter int RAM_ADD_W    = 8,
    parameter int BURSTCOUNT_W = 4
) (
    input logic                clk,
    input logic                reset,
    avalon_bram_burst_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int ADDR_W = RAM_ADD_W + OFF_W;
    localparam int DEPTH  = 2 ** RAM_ADD_W;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t                  state, state_nx;
    logic                    ready_q;
    logic [RAM_ADD_W-1:0]    ptr_q, ptr_nx;
    logic [BURSTCOUNT_W-1:0] cnt_q, cnt_nx;
    logic [RAM_ADD_W-1:0]    wa_in;
    logic [BURSTCOUNT_W-1:0] bc_eff;
    logic                    cmd_clash;
    logic                    wait_req;
    logic                    rd_en, wr_en;
    logic [RAM_ADD_W-1:0]    rd_addr, wr_addr;
    logic [DATA_W-1:0]       ram_q;
    logic                    ram_v;
    logic                    drain_done;

    logic [DATA_W-1:0] mem [DEPTH];

    assign wa_in     = bus.address[ADDR_W-1:OFF_W];
    assign bc_eff    = (bus.burstcount == '0) ? BURSTCOUNT_W'(1) : bus.burstcount;
    assign cmd_clash = bus.read && bus.write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ram_v   <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= 1'b1;
            ptr_q   <= ptr_nx;
            cnt_q   <= cnt_nx;
            ram_v   <= rd_en;
        end
    end

    // cnt_q counts beats still to be issued after the one in progress
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr_q;
        cnt_nx   = cnt_q;
        wait_req = 1'b1;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        rd_addr  = ptr_q;
        wr_addr  = ptr_q;
        case (state)
            IDLE: begin
                wait_req = !ready_q || cmd_clash;
                if (ready_q && !cmd_clash) begin
                    if (bus.read) begin
                        rd_en    = 1'b1;
                        rd_addr  = wa_in;
                        ptr_nx   = wa_in + RAM_ADD_W'(1);
                        cnt_nx   = bc_eff - BURSTCOUNT_W'(1);
                        state_nx = RD_BURST;
                    end else if (bus.write) begin
                        wr_en   = 1'b1;
                        wr_addr = wa_in;
                        ptr_nx  = wa_in + RAM_ADD_W'(1);
                        cnt_nx  = bc_eff - BURSTCOUNT_W'(1);
                        if (bc_eff != BURSTCOUNT_W'(1)) state_nx = WR_BURST;
                    end
                end
            end
            RD_BURST: begin
                if (cnt_q != '0) begin
                    rd_en  = 1'b1;
                    ptr_nx = ptr_q + RAM_ADD_W'(1);
                    cnt_nx = cnt_q - BURSTCOUNT_W'(1);
                end else if (drain_done) begin
                    state_nx = IDLE;
                end
            end
            WR_BURST: begin
                wait_req = 1'b0;
                if (bus.write) begin
                    wr_en  = 1'b1;
                    ptr_nx = ptr_q + RAM_ADD_W'(1);
                    cnt_nx = cnt_q - BURSTCOUNT_W'(1);
                    if (cnt_q == BURSTCOUNT_W'(1)) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // RAM array and its read register stay out of reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.byteenable[b]) mem[wr_addr][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
        end
        if (rd_en) ram_q <= mem[rd_addr];
    end

`ifdef AVALON_BRAM_OUT_REG_EN
    logic [DATA_W-1:0] out_q;
    logic              out_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else begin
            out_q <= ram_v ? ram_q : '0;
            out_v <= ram_v;
        end
    end

    assign drain_done        = !ram_v;
    assign bus.readdata      = out_q;
    assign bus.readdatavalid = out_v;
`else
    assign drain_done        = 1'b1;
    assign bus.readdata      = ram_v ? ram_q : '0;
    assign bus.readdatavalid = ram_v;
`endif

    assign bus.waitrequest = wait_req;
endmodule

// File: doc/avalon_bram_burst.md
# avalon_bram_burst

Parametrised Avalon-MM burst agent backed by byte-lane block RAM; next generation of the team's Avalon BRAM agent. Supports configurable data width and depth, linear incrementing read/write bursts with address wrap-around, and fixed, documented read latency with an optional output register. Sits behind the memory-controller interconnect as a local scratch/frame memory for any Avalon host in the design.

## Interface
- DATA_W, 32: data width in bits; multiple of 8, power of two, ≥ 8. BYTES = DATA_W/8.
- RAM_ADD_W, 8: log2 of depth in words; DEPTH = 2**RAM_ADD_W.
- BURSTCOUNT_W, 4: burstcount width; max legal burst = 2**(BURSTCOUNT_W-1).
- ADDR_W, RAM_ADD_W+log2(BYTES): byte-address width (derived, not overridden).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  byte address, sampled on first beat only.
- burstcount  in  BURSTCOUNT_W  beats in burst, sampled on first beat only; 0 treated as 1.
- read  in  1  read request.
- write  in  1  write request / write beat valid.
- writedata  in  DATA_W  write data.
- byteenable  in  BYTES  per-byte write enable.
- waitrequest  out  1  command not accepted this cycle.
- readdata  out  DATA_W  read data.
- readdatavalid  out  1  readdata valid this cycle.

## Operation
- Word address WA = address >> log2(BYTES); low byte-offset bits ignored. Beat i uses (WA + i) mod DEPTH, so bursts wrap past DEPTH-1 to 0.
- Accept = (read or write) and !waitrequest. Both read and write asserted together in IDLE: waitrequest=1, nothing accepted, no memory change.
- FSM states: IDLE, RD_BURST, WR_BURST.
- IDLE: waitrequest=0. Accepted read → latch WA and count, go RD_BURST. Accepted write → write beat 0 at WA; burstcount ≤ 1 stay IDLE, else latch WA, count and go WR_BURST.
- RD_BURST: one beat issued to RAM per cycle, no gaps; waitrequest=1 until the last beat's readdatavalid; then IDLE. read/write ignored.
- WR_BURST: waitrequest=0; each cycle with write=1 writes next beat with its byteenable; write=0 stalls without progress. After last beat → IDLE. read in WR_BURST ignored (illegal).
- Byteenable lanes with 0 leave the stored byte unchanged; byteenable all-zero beat still consumes a beat.
- Memory not initialised and not cleared by reset.
- Reset (any state): FSM → IDLE, counters cleared, readdatavalid=0, in-flight read beats discarded; bytes already written stay written.
- Reset values: waitrequest=1 while reset low and for exactly one cycle after release; readdatavalid=0; readdata=0.

## Timing
- Read accepted at edge k: without macro readdatavalid high cycles k+1..k+N (latency 1); waitrequest high k+1..k+N, low at k+N+1 (next command accepted there).
- Read data beats in strict address order; readdata holds 0 when readdatavalid=0.
- Write data committed to RAM at the edge of acceptance; read of same word accepted on the next cycle returns the new data.
- Beat counter width BURSTCOUNT_W; no overflow for legal burstcount.

## Configuration
- AVALON_BRAM_OUT_REG_EN defined: extra output register after the RAM; read latency 2: readdatavalid k+2..k+N+1, waitrequest high k+1..k+N+1. Reset clears the output register.
- Not defined: latency 1 as in Timing; no output register.

## Test plan
- Reset: reset low 3 cycles then high → waitrequest=1 during reset and 1 cycle after, readdatavalid=0 throughout, then waitrequest=0.
- Single write/read: write 0xDEADBEEF at address 0x10, byteenable 0xF; read 0x10 burstcount 1 → readdata 0xDEADBEEF one cycle after accept (two with macro), waitrequest low next cycle.
- Byte enables: write 0x11223344 then 0xAABBCCDD with byteenable 0b0101 at 0x20 → read returns 0x11BB33DD.
- Write burst with stalls: burstcount 4 at 0x40, data 1..4, write deasserted 2 cycles between beats 2 and 3 → read burst 4 returns 1,2,3,4 on 4 consecutive cycles.
- Wrap-around: write burst 4 at byte 0x3F8 (words 254,255,0,1) → words 0 and 1 hold beats 3 and 4; read burst from 0x3F8 matches.
- Reset mid-burst: read burst 8 accepted, reset pulled low after 3rd readdatavalid → readdatavalid falls immediately, FSM IDLE after release, previously written data intact on re-read.
